// File: rtl/dmem_delay_ctrl_if.sv
// Request/response bundle between the M-stage and the fixed-latency data memory.
// With DMEM_ADDR_CHECK_EN defined the bundle also carries the ErrM completion flag.
interface dmem_delay_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ReqM;
    logic             WEM;
    logic [WIDTH-1:0] AddrM;
    logic [WIDTH-1:0] WDM;
    logic [4:0]       TagInM;
    logic             ReadyM;
    logic             BusyM;
    logic             ValidM;
    logic [WIDTH-1:0] RDM;
    logic [4:0]       TagOutM;
    logic             LoadDoneM;
    logic             StateM;
`ifdef DMEM_ADDR_CHECK_EN
    logic             ErrM;

    modport master (
        output ReqM, WEM, AddrM, WDM, TagInM,
        input  ReadyM, BusyM, ValidM, RDM, TagOutM, LoadDoneM, StateM, ErrM
    );
    modport slave (
        input  ReqM, WEM, AddrM, WDM, TagInM,
        output ReadyM, BusyM, ValidM, RDM, TagOutM, LoadDoneM, StateM, ErrM
    );
`else
    modport master (
        output ReqM, WEM, AddrM, WDM, TagInM,
        input  ReadyM, BusyM, ValidM, RDM, TagOutM, LoadDoneM, StateM
    );
    modport slave (
        input  ReqM, WEM, AddrM, WDM, TagInM,
        output ReadyM, BusyM, ValidM, RDM, TagOutM, LoadDoneM, StateM
    );
`endif
endinterface

// File: rtl/dmem_delay_ctrl.sv
// Data memory with a fixed LATENCY per access, one access in flight at a time.
// Optional macro DMEM_ADDR_CHECK_EN flags (and suppresses) out-of-range addresses via ErrM.
//
// Handshake: a request is accepted at a rising edge where ReqM & ReadyM; requests
// seen while BusyM is high are dropped. ValidM is a one-cycle pulse LATENCY cycles
// after acceptance; ReadyM is already high in that cycle. StateM mirrors the FSM.
module dmem_delay_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 3
) (
    input  logic                CLK,
    input  logic                CLR,
    dmem_delay_ctrl_if.slave    bus
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t                  state, stateNext;
    logic                    accept, done;
    logic [3:0]              count;
    logic [DEPTH_LOG2-1:0]   idxL;
    logic                    weL;
    logic [WIDTH-1:0]        wdL;
    logic [4:0]              tagL;
    logic                    validQ, loadDoneQ;
    logic [WIDTH-1:0]        rdQ;
    logic [4:0]              tagOutQ;
    logic                    blockL;
    logic [WIDTH-1:0]        mem [2**DEPTH_LOG2];

    always_ff @(posedge CLK) begin
        if (CLR) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ReqM) begin
                    accept    = 1'b1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    done      = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef DMEM_ADDR_CHECK_EN
    logic errL, errQ;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            errL <= 1'b0;
            errQ <= 1'b0;
        end else begin
            if (accept) errL <= |bus.AddrM[WIDTH-1:DEPTH_LOG2+2];
            errQ <= done & errL;
        end
    end

    assign blockL   = errL;
    assign bus.ErrM = errQ;
`else
    assign blockL = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            count     <= 4'd0;
            idxL      <= '0;
            weL       <= 1'b0;
            wdL       <= '0;
            tagL      <= 5'd0;
            validQ    <= 1'b0;
            loadDoneQ <= 1'b0;
            rdQ       <= '0;
            tagOutQ   <= 5'd0;
        end else begin
            if (accept) begin
                count <= 4'(LATENCY - 1);
                idxL  <= bus.AddrM[DEPTH_LOG2+1:2];
                weL   <= bus.WEM;
                wdL   <= bus.WDM;
                tagL  <= bus.TagInM;
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            validQ    <= done;
            loadDoneQ <= done & ~weL;
            if (done && !weL) begin
                rdQ     <= blockL ? '0 : mem[idxL];
                tagOutQ <= tagL;
            end
        end
    end

    // Array is deliberately outside reset so an aborted access leaves contents intact.
    always_ff @(posedge CLK) begin
        if (!CLR && done && weL && !blockL) mem[idxL] <= wdL;
    end

    assign bus.ReadyM    = (state == IDLE);
    assign bus.BusyM     = (state == WAIT);
    assign bus.ValidM    = validQ;
    assign bus.LoadDoneM = loadDoneQ;
    assign bus.RDM       = rdQ;
    assign bus.TagOutM   = tagOutQ;
    assign bus.StateM    = state;
endmodule
